// File: rtl/kitchen_timer_ctrl_if.sv
// Counter-side bus between the kitchen-timer sequencer (master) and its BCD mm:ss counter (slave).
interface kitchen_timer_ctrl_if;
    logic [15:0] cnt_value;
    logic        cnt_tick;
    logic        cnt_dn;
    logic        cnt_load;
    logic [15:0] cnt_load_val;

    modport master (
        input  cnt_value,
        output cnt_tick,
        output cnt_dn,
        output cnt_load,
        output cnt_load_val
    );

    modport slave (
        output cnt_value,
        input  cnt_tick,
        input  cnt_dn,
        input  cnt_load,
        input  cnt_load_val
    );
endinterface

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen-timer sequencer: buttons -> IDLE/RUN/PAUSE/ALARM, 1 s prescaler, counter tick/load/direction.
// Optional build macro AUTO_SILENCE_EN: alarm silences itself after ALARM_SECS seconds.
module kitchen_timer_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic                 btn_clear,
    input  logic                 btn_min,
    input  logic                 btn_sec,
    kitchen_timer_ctrl_if.master cnt,
    output logic [15:0]          preset,
    output logic                 running,
    output logic                 alarm
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SECS_LAST = SW'(ALARM_SECS - 1);

`ifdef AUTO_SILENCE_EN
    localparam bit AUTO_SILENCE = 1'b1;
`else
    localparam bit AUTO_SILENCE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t        state_q, state_d;
    logic [15:0]   preset_q, preset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] secs_q, secs_d;
    logic          dn_q, dn_d;
    logic          tick_q, tick_d;
    logic          load_q, load_d;
    logic [15:0]   load_val_q, load_val_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;
    logic [15:0]   preset_inc;

    // Two-digit BCD increment over 00..59.
    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    always_comb begin
        preset_inc = preset_q;
        if (btn_min) preset_inc[15:8] = bcd_inc59(preset_q[15:8]);
        if (btn_sec) preset_inc[7:0]  = bcd_inc59(preset_q[7:0]);
    end

    always_comb begin
        state_d    = state_q;
        preset_d   = preset_q;
        presc_d    = presc_q;
        secs_d     = secs_q;
        dn_d       = dn_q;
        tick_d     = 1'b0;
        load_d     = 1'b0;
        load_val_d = load_val_q;

        if (btn_clear) begin
            state_d    = S_IDLE;
            preset_d   = '0;
            presc_d    = '0;
            secs_d     = '0;
            load_d     = 1'b1;
            load_val_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        presc_d = '0;
                        dn_d    = (preset_q != 16'h0000);
                        state_d = S_RUN;
                    end else if (btn_min || btn_sec) begin
                        preset_d   = preset_inc;
                        load_d     = 1'b1;
                        load_val_d = preset_inc;
                    end
                end
                S_RUN: begin
                    // Zero check outranks the tick so a down-count never wraps past 00:00.
                    if (btn_start) begin
                        state_d = S_PAUSE;
                    end else if (dn_q && cnt.cnt_value == 16'h0000) begin
                        state_d = S_ALARM;
                        presc_d = '0;
                        secs_d  = '0;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (!dn_q && cnt.cnt_value == 16'h5959) begin
                            state_d = S_ALARM;
                            secs_d  = '0;
                        end else begin
                            tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) state_d = S_RUN;
                end
                S_ALARM: begin
                    if (btn_start) begin
                        state_d    = S_IDLE;
                        load_d     = 1'b1;
                        load_val_d = preset_q;
                    end else if (AUTO_SILENCE) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            if (secs_q == SECS_LAST) begin
                                state_d    = S_IDLE;
                                load_d     = 1'b1;
                                load_val_d = preset_q;
                            end else begin
                                secs_d = secs_q + 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
    end

    // load_q resets high: the counter has no reset and is zeroed by this strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            preset_q   <= '0;
            presc_q    <= '0;
            secs_q     <= '0;
            dn_q       <= 1'b0;
            tick_q     <= 1'b0;
            load_q     <= 1'b1;
            load_val_q <= '0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            presc_q    <= presc_d;
            secs_q     <= secs_d;
            dn_q       <= dn_d;
            tick_q     <= tick_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            running_q  <= running_d;
            alarm_q    <= alarm_d;
        end
    end

    assign cnt.cnt_tick     = tick_q;
    assign cnt.cnt_dn       = dn_q;
    assign cnt.cnt_load     = load_q;
    assign cnt.cnt_load_val = load_val_q;
    assign preset           = preset_q;
    assign running          = running_q;
    assign alarm            = alarm_q;
endmodule
